// File: rtl/mem_access_unit.sv
// Data-memory initiator: byte/half/word loads and stores onto a word memory.
// Sub-word stores use read-modify-write; loads sign- or zero-extend.
module mem_access_unit #(
  parameter int DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writedata,
  output logic        mem_memread,
  output logic        mem_memwrite,
  input  logic [31:0] mem_readdata
);

  typedef enum logic [2:0] {
    IDLE, LD_RD, LD_CAP, ST_WR, RMW_RD, RMW_MRG, RMW_WR
  } state_t;

  state_t      state, nstate;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic        uns_q;
  logic [31:0] wdata_q;
  logic [31:0] wd_q;
  logic        err_pend;
  logic        accept;
  logic        bad;
  logic [7:0]  lb;
  logic [15:0] lh;
  logic [31:0] ld_val;
  logic [31:0] mask;
  logic [31:0] ins;
  logic [31:0] merged;

  // a rejected request holds ready low for the cycle before its err pulse
  assign ready  = (state == IDLE) && !err_pend;
  assign accept = ready && req;
  assign mem_writedata = wd_q;

  always_comb begin
    bad = 1'b0;
    unique case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = addr[0];
      2'b10:   bad = |addr[1:0];
      default: bad = 1'b1;
    endcase
    if ({2'b00, addr[31:2]} >= 32'(DEPTH))
      bad = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: begin
        if (accept && !bad) begin
          if (!we)                nstate = LD_RD;
          else if (size == 2'b10) nstate = ST_WR;
          else                    nstate = RMW_RD;
        end
      end
      LD_RD:   nstate = LD_CAP;
      LD_CAP:  nstate = IDLE;
      ST_WR:   nstate = IDLE;
      RMW_RD:  nstate = RMW_MRG;
      RMW_MRG: nstate = RMW_WR;
      RMW_WR:  nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    mem_memread  = (state == LD_RD) || (state == RMW_RD);
    mem_memwrite = (state == ST_WR) || (state == RMW_WR);
  end

  always_comb begin
    lb = mem_readdata[7:0];
    unique case (off_q)
      2'd0: lb = mem_readdata[7:0];
      2'd1: lb = mem_readdata[15:8];
      2'd2: lb = mem_readdata[23:16];
      2'd3: lb = mem_readdata[31:24];
    endcase
    lh = off_q[1] ? mem_readdata[31:16] : mem_readdata[15:0];
    ld_val = mem_readdata;
    unique case (size_q)
      2'b00:   ld_val = {{24{~uns_q & lb[7]}}, lb};
      2'b01:   ld_val = {{16{~uns_q & lh[15]}}, lh};
      default: ld_val = mem_readdata;
    endcase
  end

  always_comb begin
    mask = 32'h0000_FFFF;
    ins  = {16'h0, wdata_q[15:0]};
    if (size_q == 2'b00) begin
      mask = 32'h0000_00FF;
      ins  = {24'h0, wdata_q[7:0]};
    end
    mask   = mask << {off_q, 3'b000};
    ins    = ins << {off_q, 3'b000};
    merged = (mem_readdata & ~mask) | ins;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done        <= 1'b0;
      err         <= 1'b0;
      err_pend    <= 1'b0;
      rdata       <= 32'h0;
      mem_address <= 32'h0;
      wd_q        <= 32'h0;
      size_q      <= 2'b00;
      off_q       <= 2'b00;
      uns_q       <= 1'b0;
      wdata_q     <= 32'h0;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      err_pend <= 1'b0;
      if (err_pend) begin
        done <= 1'b1;
        err  <= 1'b1;
      end
      if (accept) begin
        size_q      <= size;
        off_q       <= addr[1:0];
        uns_q       <= unsigned_ld;
        wdata_q     <= wdata;
        mem_address <= {2'b00, addr[31:2]};
        if (bad)
          err_pend <= 1'b1;
        else if (we && size == 2'b10)
          wd_q <= wdata;
      end
      if (state == LD_CAP) begin
        rdata <= ld_val;
        done  <= 1'b1;
      end
      if (state == ST_WR || state == RMW_WR)
        done <= 1'b1;
      if (state == RMW_MRG)
        wd_q <= merged;
    end
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Initiator side of the word-addressed data-memory interface in the single-cycle/lab CPU datapath. Accepts byte-addressed load/store requests (byte, half, word) from the core and converts them into word-level memread/memwrite transactions. Handles sign/zero extension on loads and read-modify-write for sub-word stores. Sits between the core's MEM stage and the data memory, which has a registered read and a write on posedge clk.

Parameters:
DEPTH, 32, number of 32-bit words in the attached data memory; word indices >= DEPTH are out of range.

Ports:
clk  input  1  system clock; all state changes on posedge
rst_n  input  1  synchronous active-low reset
req  input  1  request valid; accepted only when ready=1
we  input  1  1=store, 0=load
size  input  2  00 byte, 01 half, 10 word, 11 reserved (error)
unsigned_ld  input  1  1=zero-extend sub-word load, 0=sign-extend
addr  input  32  byte address
wdata  input  32  store data; low byte/half used for sub-word stores
ready  output  1  unit idle, can accept req
done  output  1  one-cycle completion pulse
err  output  1  valid with done; request rejected, no memory write
rdata  output  32  load result; held until next load completes
mem_address  output  32  word index to memory = {2'b00, addr[31:2]}
mem_writedata  output  32  word written to memory
mem_memread  output  1  memory read strobe
mem_memwrite  output  1  memory write strobe
mem_readdata  input  32  memory read data, valid the cycle after a memread edge

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, done=0, err=0, rdata=0, mem_address=0, mem_writedata=0, mem_memread=0, mem_memwrite=0. ready=1 after reset.
- Memory strobes are registered or decoded from state. mem_memread and mem_memwrite are never both 1. Memory gives read priority, so both high is a bug.
- Little-endian byte lanes: addr[1:0]=0 maps to bits 7:0, 3 maps to bits 31:24. A half at addr[1]=0 maps to bits 15:0, addr[1]=1 maps to bits 31:16.
- Accept: on a posedge with state=IDLE and req=1, latch we/size/unsigned_ld/addr/wdata. Inputs are ignored at all other times.
- Error check at accept: size=11, half with addr[0]=1, word with addr[1:0]!=0, or addr[31:2]>=DEPTH.
  - Stay IDLE; next cycle done=1, err=1, no strobes.
  - rdata is unchanged.
- FSM states: IDLE, LD_RD, LD_CAP, ST_WR, RMW_RD, RMW_MRG, RMW_WR.
- Load: IDLE -> LD_RD -> LD_CAP -> IDLE.
  - LD_RD: mem_memread=1.
  - LD_CAP: mem_readdata is valid; at the exiting edge, rdata <= extracted and extended lane, done <= 1.
  - done is high 2 cycles after the accept edge.
- Word store: IDLE -> ST_WR -> IDLE.
  - ST_WR: mem_memwrite=1, mem_writedata=wdata.
  - done is high 1 cycle after the accept edge.
- Sub-word store: IDLE -> RMW_RD -> RMW_MRG -> RMW_WR -> IDLE.
  - RMW_RD: mem_memread=1.
  - RMW_MRG: merge register <= mem_readdata with the target lane replaced by wdata[7:0] or wdata[15:0].
  - RMW_WR: mem_memwrite=1 with the merged word.
  - done is high 3 cycles after the accept edge.
- ready=1 only in IDLE. ready=1 in the same cycle as done, so a new request can be accepted in the done cycle (back-to-back, no bubble).
- done and err are one-cycle pulses; err=0 whenever done marks a successful access.
- rdata is not modified by stores.
- Reset mid-operation: the FSM returns to IDLE and the strobes drop from the cycle after the reset edge. No done pulse is issued for the aborted request.
  - A write strobe that is high at the reset edge itself may commit in memory.
  - An RMW aborted before RMW_WR leaves memory unchanged.

Test Plan:
- After reset, memory word1=0x00000054: load word addr=4 -> done 2 cycles after accept, rdata=0x00000054, err=0, exactly one memread cycle, no memwrite.
- Memory word2=0x0000000B: store byte addr=9 wdata=0x123456FF -> memread then memwrite, word2=0x0000FF0B, done 3 cycles after accept. Then load byte addr=9 signed -> rdata=0xFFFFFFFF; unsigned -> 0x000000FF.
- Store half addr=6 wdata=0xABCD8001 -> word1=0x80010054. Load half addr=6 signed -> 0xFFFF8001, unsigned -> 0x00008001. Store word addr=12 wdata=0xDEADBEEF -> done 1 cycle after accept; load word addr=12 returns 0xDEADBEEF.
- Errors, each giving done=1, err=1 one cycle after accept, no strobes, rdata unchanged:
  - load word addr=6 (misaligned);
  - half addr=3 (misaligned);
  - size=11;
  - load word addr=128 with DEPTH=32 (out of range).
- Hold req=1 across load addr=4, store word addr=8, load addr=8. Each request is accepted in the prior done cycle; the final rdata equals the stored value; strobes are never both high.
- Assert rst_n=0 while in RMW_MRG during a byte store to addr=8 -> no memwrite, word2 unchanged, no done; ready=1 and all outputs 0 after the reset edge.
